cve2_lsu_obi: RTL and testbench

Load/store unit that executes one memory access per request from the ID/EX stage over an OBI data port, splitting misaligned accesses into two aligned transactions. Load data is merged, aligned and sign/zero-extended here. The result goes straight to the writeback passthrough, which consumes `rf_wdata_lsu_o`, `rf_we_lsu_o`, `lsu_resp_valid_o` and `lsu_resp_err_o`.

---
 rtl/cve2_pkg.sv | 40 ++++
 rtl/cve2_lsu_obi_if.sv | 22 ++
 rtl/cve2_lsu_align.sv | 76 +++++++
 rtl/cve2_lsu_obi.sv | 191 +++++++++++++++++++
 tb/tb_cve2_lsu_obi.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cve2_pkg.sv
// Shared types and helpers for the load/store unit.
package cve2_pkg;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_type_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GNT1 = 3'd1,
    RV1  = 3'd2,
    GNT2 = 3'd3,
    RV2  = 3'd4
  } lsu_state_e;

  // Byte enables of both parts: low nibble is part 1, high nibble part 2.
  // Shifting the access footprint across an 8-lane window makes the bytes
  // that spill past lane 3 land exactly in the part-2 nibble.
  function automatic logic [7:0] be_pair(input logic [1:0] lsu_type,
                                         input logic [1:0] offset);
    logic [7:0] base;
    case (lsu_type)
      LSU_HALF: base = 8'h03;
      LSU_BYTE: base = 8'h01;
      default:  base = 8'h0F;
    endcase
    return base << offset;
  endfunction

  // An access is misaligned exactly when some byte spills into part 2.
  function automatic logic is_misaligned(input logic [1:0] lsu_type,
                                         input logic [1:0] offset);
    logic [7:0] pair;
    pair = be_pair(lsu_type, offset);
    return pair[7:4] != 4'b0000;
  endfunction

endpackage

// File: rtl/cve2_lsu_obi_if.sv
// OBI data port between the load/store unit and the memory side.
interface cve2_lsu_obi_if;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/cve2_lsu_align.sv
// Byte-lane datapath of the LSU: byte enables, store rotation and
// load merge/rotate/extend. Purely combinational.
module cve2_lsu_align
  import cve2_pkg::*;
(
  input  logic [1:0]  lsu_type,
  input  logic [1:0]  offset,
  input  logic        second_part,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [31:0] rdata_q,
  output logic [3:0]  be,
  output logic [31:0] wdata_rot,
  output logic [31:0] rdata_masked,
  output logic [31:0] load_data
);

  logic [7:0]  be_pair_s;
  logic [31:0] mask_s;
  logic [31:0] merged_s;
  logic [31:0] rotated_s;

  // Select the byte enables of the part currently on the bus.
  always_comb begin
    be_pair_s = be_pair(lsu_type, offset);
    if (second_part) begin
      be = be_pair_s[7:4];
    end else begin
      be = be_pair_s[3:0];
    end
  end

  // Keep only the lanes this part owns, then join with the saved part 1.
  always_comb begin
    mask_s       = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    rdata_masked = rdata & mask_s;
    if (second_part) begin
      merged_s = rdata_masked | rdata_q;
    end else begin
      merged_s = rdata_masked;
    end
  end

  // Rotate store data onto its lanes and load data back down to lane 0.
  always_comb begin
    case (offset)
      2'd1: begin
        wdata_rot = {wdata[23:0], wdata[31:24]};
        rotated_s = {merged_s[7:0], merged_s[31:8]};
      end
      2'd2: begin
        wdata_rot = {wdata[15:0], wdata[31:16]};
        rotated_s = {merged_s[15:0], merged_s[31:16]};
      end
      2'd3: begin
        wdata_rot = {wdata[7:0], wdata[31:8]};
        rotated_s = {merged_s[23:0], merged_s[31:24]};
      end
      default: begin
        wdata_rot = wdata;
        rotated_s = merged_s;
      end
    endcase
  end

  // Extract the loaded quantity and extend it to a full register.
  always_comb begin
    case (lsu_type)
      LSU_HALF: load_data = {{16{sign_ext & rotated_s[15]}}, rotated_s[15:0]};
      LSU_BYTE: load_data = {{24{sign_ext & rotated_s[7]}}, rotated_s[7:0]};
      default:  load_data = rotated_s;
    endcase
  end

endmodule

// File: rtl/cve2_lsu_obi.sv
// Load/store unit: one access at a time over OBI, misaligned accesses
// split into two aligned transactions.
module cve2_lsu_obi
  import cve2_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_type_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [31:0]           lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  cve2_lsu_obi_if.master        obi,
  output logic                  lsu_busy_o,
  output logic                  lsu_resp_valid_o,
  output logic                  lsu_resp_err_o,
  output logic                  rf_we_lsu_o,
  output logic [31:0]           rf_wdata_lsu_o
);

  lsu_state_e  state_r, state_next_s;
  logic        we_r, sign_r;
  logic [1:0]  type_r;
  logic [31:0] addr_r, wdata_r, rdata_r;

  logic        capture_s, store_rdata_s, resp_s, misaligned_s, second_part_s;
  logic        sign_s, we_s;
  logic [1:0]  type_s, offset_s;
  logic [31:0] wdata_s, word_addr_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rot_s, rdata_masked_s, load_data_s;

  // Datapath operands: live inputs in the issue cycle, captured ones after.
  always_comb begin
    if (state_r == IDLE) begin
      type_s      = lsu_type_i;
      offset_s    = lsu_addr_i[1:0];
      sign_s      = lsu_sign_ext_i;
      we_s        = lsu_we_i;
      wdata_s     = lsu_wdata_i;
      word_addr_s = {lsu_addr_i[31:2], 2'b00};
    end else begin
      type_s      = type_r;
      offset_s    = addr_r[1:0];
      sign_s      = sign_r;
      we_s        = we_r;
      wdata_s     = wdata_r;
      word_addr_s = {addr_r[31:2], 2'b00};
    end
    second_part_s = (state_r == GNT2) || (state_r == RV2);
    misaligned_s  = is_misaligned(type_r, addr_r[1:0]);
  end

  cve2_lsu_align u_align (
    .lsu_type     (type_s),
    .offset       (offset_s),
    .second_part  (second_part_s),
    .sign_ext     (sign_s),
    .wdata        (wdata_s),
    .rdata        (obi.data_rdata),
    .rdata_q      (rdata_r),
    .be           (be_s),
    .wdata_rot    (wdata_rot_s),
    .rdata_masked (rdata_masked_s),
    .load_data    (load_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request capture and part-1 load data holding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_r    <= 1'b0;
      sign_r  <= 1'b0;
      type_r  <= 2'b00;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
    end else begin
      if (capture_s) begin
        we_r    <= lsu_we_i;
        sign_r  <= lsu_sign_ext_i;
        type_r  <= lsu_type_i;
        addr_r  <= lsu_addr_i;
        wdata_r <= lsu_wdata_i;
      end
      if (store_rdata_s) begin
        rdata_r <= rdata_masked_s;
      end
    end
  end

  // Next state, OBI request side and writeback response.
  always_comb begin
    state_next_s     = state_r;
    capture_s        = 1'b0;
    store_rdata_s    = 1'b0;
    resp_s           = 1'b0;
    obi.data_req     = 1'b0;
    obi.data_addr    = 32'h0000_0000;
    obi.data_we      = 1'b0;
    obi.data_be      = 4'b0000;
    obi.data_wdata   = 32'h0000_0000;
    lsu_resp_valid_o = 1'b0;
    lsu_resp_err_o   = 1'b0;
    rf_we_lsu_o      = 1'b0;
    rf_wdata_lsu_o   = 32'h0000_0000;

    case (state_r)
      IDLE: begin
        // rst_ni gating keeps the bus quiet while reset is asserted.
        if (lsu_req_i && rst_ni) begin
          capture_s    = 1'b1;
          obi.data_req = 1'b1;
          state_next_s = obi.data_gnt ? RV1 : GNT1;
        end else begin
          state_next_s = IDLE;
        end
      end
      GNT1: begin
        obi.data_req = 1'b1;
        if (obi.data_gnt) begin
          state_next_s = RV1;
        end else begin
          state_next_s = GNT1;
        end
      end
      RV1: begin
        if (obi.data_rvalid) begin
          if (misaligned_s && !obi.data_err) begin
            store_rdata_s = 1'b1;
            state_next_s  = GNT2;
          end else begin
            resp_s       = 1'b1;
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = RV1;
        end
      end
      GNT2: begin
        obi.data_req = 1'b1;
        if (obi.data_gnt) begin
          state_next_s = RV2;
        end else begin
          state_next_s = GNT2;
        end
      end
      RV2: begin
        if (obi.data_rvalid) begin
          resp_s       = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = RV2;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    if (obi.data_req) begin
      obi.data_addr  = second_part_s ? (word_addr_s + 32'd4) : word_addr_s;
      obi.data_we    = we_s;
      obi.data_be    = be_s;
      obi.data_wdata = we_s ? wdata_rot_s : 32'h0000_0000;
    end else begin
      obi.data_addr  = 32'h0000_0000;
    end

    if (resp_s) begin
      lsu_resp_valid_o = 1'b1;
      lsu_resp_err_o   = obi.data_err;
      rf_we_lsu_o      = ~we_r & ~obi.data_err;
      rf_wdata_lsu_o   = rf_we_lsu_o ? load_data_s : 32'h0000_0000;
    end else begin
      lsu_resp_valid_o = 1'b0;
    end
  end

  assign lsu_busy_o = (state_r != IDLE);

endmodule

// File: tb/tb_cve2_lsu_obi.sv
// Randomized bench for cve2_lsu_obi with a byte-level reference model.
module tb_cve2_lsu_obi;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_resp_valid_o, lsu_resp_err_o, rf_we_lsu_o;
  logic [31:0] rf_wdata_lsu_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] last_rf_wdata;
  logic        last_err, last_rf_we;

  always #5 clk = ~clk;

  cve2_lsu_obi_if obi ();

  cve2_lsu_obi dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_type_i       (lsu_type_i),
    .lsu_sign_ext_i   (lsu_sign_ext_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .obi              (obi),
    .lsu_busy_o       (lsu_busy_o),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_err_o   (lsu_resp_err_o),
    .rf_we_lsu_o      (rf_we_lsu_o),
    .rf_wdata_lsu_o   (rf_wdata_lsu_o)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] t);
    case (t)
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 4;
    endcase
  endfunction

  // One complete access; the bench plays the memory side with random delays.
  task automatic run_access(input logic we, input logic [1:0] t, input logic sext,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic err0, input logic err1,
                            input int max_gd, input int max_rd);
    int          off, sz, nparts, last_part, gd, rdl;
    logic [3:0]  exp_be [2];
    logic [31:0] exp_addr [2];
    logic [31:0] rd [2];
    logic [31:0] exp_wd, exp_res;
    logic        exp_err, exp_rf_we;

    off    = int'(addr[1:0]);
    sz     = size_of(t);
    nparts = (off + sz > 4) ? 2 : 1;
    exp_be[0] = 4'b0000;
    exp_be[1] = 4'b0000;
    for (int k = 0; k < sz; k++) begin
      int b;
      b = off + k;
      if (b < 4) exp_be[0][b] = 1'b1;
      else       exp_be[1][b - 4] = 1'b1;
    end
    exp_addr[0] = addr & 32'hFFFF_FFFC;
    exp_addr[1] = exp_addr[0] + 32'd4;
    for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wdata[8*((j - off) & 3) +: 8];
    if (!we) exp_wd = 32'h0;
    rd[0] = rd0;
    rd[1] = rd1;
    exp_res = 32'h0;
    for (int k = 0; k < sz; k++) begin
      int b;
      b = off + k;
      exp_res[8*k +: 8] = rd[b / 4][8*(b % 4) +: 8];
    end
    if (sz < 4 && sext && exp_res[8*sz - 1]) begin
      for (int k = sz; k < 4; k++) exp_res[8*k +: 8] = 8'hFF;
    end
    last_part = (nparts == 2 && err0) ? 0 : nparts - 1;
    exp_err   = (last_part == 0) ? err0 : err1;
    exp_rf_we = !we && !exp_err;

    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = t;
    lsu_sign_ext_i = sext; lsu_addr_i = addr; lsu_wdata_i = wdata;
    for (int p = 0; p <= last_part; p++) begin
      gd = $urandom_range(max_gd, 0);
      for (int d = 0; d <= gd; d++) begin
        obi.data_gnt    = (d == gd);
        obi.data_rvalid = 1'($urandom_range(1, 0));
        obi.data_err    = 1'($urandom_range(1, 0));
        #1;
        chk_eq($sformatf("req p%0d", p), 32'(obi.data_req), 32'd1);
        chk_eq($sformatf("addr p%0d", p), obi.data_addr, exp_addr[p]);
        chk_eq($sformatf("be p%0d", p), 32'(obi.data_be), 32'(exp_be[p]));
        chk_eq($sformatf("we p%0d", p), 32'(obi.data_we), 32'(we));
        chk_eq($sformatf("wdata p%0d", p), obi.data_wdata, exp_wd);
        chk_eq("busy in a phase", 32'(lsu_busy_o), (p == 0 && d == 0) ? 32'd0 : 32'd1);
        chk_eq("no resp in a phase", 32'(lsu_resp_valid_o), 32'd0);
        @(negedge clk);
        // The ID side keeps requesting; the captured values must be used.
        lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
        lsu_type_i = 2'($urandom); lsu_we_i = 1'($urandom);
      end
      obi.data_gnt = 1'b0; obi.data_rvalid = 1'b0; obi.data_err = 1'b0;
      rdl = $urandom_range(max_rd, 0);
      for (int d = 0; d < rdl; d++) begin
        #1;
        chk_eq("req low in r wait", 32'(obi.data_req), 32'd0);
        chk_eq("no resp in r wait", 32'(lsu_resp_valid_o), 32'd0);
        @(negedge clk);
      end
      obi.data_rvalid = 1'b1;
      obi.data_rdata  = rd[p];
      obi.data_err    = (p == 0) ? err0 : err1;
      #1;
      chk_eq("req low in r beat", 32'(obi.data_req), 32'd0);
      if (p == last_part) begin
        chk_eq("resp_valid", 32'(lsu_resp_valid_o), 32'd1);
        chk_eq("resp_err", 32'(lsu_resp_err_o), 32'(exp_err));
        chk_eq("rf_we", 32'(rf_we_lsu_o), 32'(exp_rf_we));
        chk_eq("rf_wdata", rf_wdata_lsu_o, exp_rf_we ? exp_res : 32'h0);
        last_rf_wdata = rf_wdata_lsu_o;
        last_err      = lsu_resp_err_o;
        last_rf_we    = rf_we_lsu_o;
      end else begin
        chk_eq("no resp on part 1", 32'(lsu_resp_valid_o), 32'd0);
      end
      @(negedge clk);
      obi.data_rvalid = 1'b0; obi.data_err = 1'b0; obi.data_rdata = $urandom;
    end
    lsu_req_i = 1'b0;
    #1;
    chk_eq("idle after access", 32'(lsu_busy_o), 32'd0);
    chk_eq("no further req", 32'(obi.data_req), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_ni = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'b00;
    lsu_sign_ext_i = 1'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
    obi.data_gnt = 1'b0; obi.data_rvalid = 1'b0; obi.data_rdata = 32'h0; obi.data_err = 1'b0;
    #1;
    chk_eq("rst req", 32'(obi.data_req), 32'd0);
    chk_eq("rst we", 32'(obi.data_we), 32'd0);
    chk_eq("rst be", 32'(obi.data_be), 32'd0);
    chk_eq("rst addr", obi.data_addr, 32'h0);
    chk_eq("rst wdata", obi.data_wdata, 32'h0);
    chk_eq("rst busy", 32'(lsu_busy_o), 32'd0);
    chk_eq("rst resp", 32'(lsu_resp_valid_o), 32'd0);
    chk_eq("rst err", 32'(lsu_resp_err_o), 32'd0);
    chk_eq("rst rf_we", 32'(rf_we_lsu_o), 32'd0);
    chk_eq("rst rf_wdata", rf_wdata_lsu_o, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    run_access(1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 0, 0);
    chk_eq("lw aligned value", last_rf_wdata, 32'hDEAD_BEEF);
    run_access(1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 0, 0);
    chk_eq("lb sext value", last_rf_wdata, 32'hFFFF_FF80);
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_1003, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1, 1);
    chk_eq("lbu value", last_rf_wdata, 32'h0000_0080);
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_1002, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1'b0, 1'b0, 0, 0);
    chk_eq("lw misaligned value", last_rf_wdata, 32'h3344_AABB);
    run_access(1'b1, 2'b01, 1'b0, 32'h0000_2003, 32'h0000_BEEF, 32'h0, 32'h0, 1'b0, 1'b0, 1, 1);
    chk_eq("sh rf_we", 32'(last_rf_we), 32'd0);
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 0, 0);
    chk_eq("abort err", 32'(last_err), 32'd1);
    run_access(1'b0, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0102_0304, 32'hA0B0_C0D0, 1'b0, 1'b0, 1, 1);
    run_access(1'b0, 2'b11, 1'b1, 32'h0000_5002, 32'h0, 32'hF00D_CAFE, 32'h9988_7766, 1'b0, 1'b1, 2, 1);

    for (int n = 0; n < 200; n++) begin
      run_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                 $urandom, $urandom, ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0), 2, 2);
    end

    // Grant withheld in GNT1, then an asynchronous reset mid-access.
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_type_i = 2'b00; lsu_sign_ext_i = 1'b0;
    lsu_addr_i = 32'h0000_4000; lsu_wdata_i = 32'h5555_AAAA; obi.data_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk_eq("hold req", 32'(obi.data_req), 32'd1);
      chk_eq("hold addr", obi.data_addr, 32'h0000_4000);
      chk_eq("hold be", 32'(obi.data_be), 32'hF);
      chk_eq("hold we", 32'(obi.data_we), 32'd1);
      chk_eq("hold wdata", obi.data_wdata, 32'h5555_AAAA);
      @(negedge clk);
      lsu_addr_i = $urandom; lsu_wdata_i = $urandom; lsu_we_i = 1'($urandom);
    end
    rst_ni = 1'b0;
    lsu_req_i = 1'b0;
    #1;
    chk_eq("reset drops req", 32'(obi.data_req), 32'd0);
    chk_eq("reset clears busy", 32'(lsu_busy_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      obi.data_rvalid = 1'b1; obi.data_rdata = $urandom;
      #1;
      chk_eq("no resp after reset", 32'(lsu_resp_valid_o), 32'd0);
      chk_eq("no req after reset", 32'(obi.data_req), 32'd0);
      @(negedge clk);
    end
    obi.data_rvalid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
